fetch_queue_unit: RTL and testbench
===================================

// Module: fetch_queue_unit
// PURPOSE
//  Parametrised instruction-fetch front end. Replaces the single-entry PC/IF-ID path.
//  Keeps up to MAX_OUTSTANDING imem requests in flight and buffers responses in a DEPTH-entry {pc,inst} queue.
//  Decode consumes the queue with valid/ready. A redirect flushes the queue and discards stale in-flight responses.
// PARAMETERS
//  XLEN            32  address/PC width
//  ILEN            32  instruction width
//  DEPTH           4   instruction queue entries (>=2)
//  MAX_OUTSTANDING 2   max imem requests in flight, stale ones included (>=1)
//  RESET_PC        0   first fetch address after reset
// PORTS
//  clk             in   1         single clock; everything on posedge
//  reset_n         in   1         asynchronous, active-low reset
//  redirect_valid  in   1         flush and restart fetch at redirect_pc
//  redirect_pc     in   XLEN      new fetch address (word aligned)
//  imem_req_valid  out  1         fetch request
//  imem_req_ready  in   1         imem accepts request
//  imem_req_addr   out  XLEN      fetch address (= fetch PC)
//  imem_resp_valid in   1         response data valid; responses return in request order
//  imem_resp_ready out  1         tied 1 once running; space is guaranteed by credits
//  imem_resp_data  in   ILEN      instruction word
//  out_valid       out  1         queue head valid toward decode
//  out_ready       in   1         decode accepts head
//  out_inst        out  ILEN      head instruction
//  out_pc          out  XLEN      head PC
//  occupancy       out  clog2(DEPTH+1)  queue entry count
// BEHAVIOUR
//  Reset (async assert):
//   fetch_pc=RESET_PC; queue empty; in_flight=0; discard=0; run=0.
//   All valid outputs 0; imem_resp_ready=0; occupancy=0.
//  run:
//   Sets on the first clk edge after reset release. imem_req_valid and imem_resp_ready are 0 while run=0.
//  Issue rule:
//   imem_req_valid = run & !redirect_valid & in_flight<MAX_OUTSTANDING & (occupancy + in_flight - discard) < DEPTH.
//   imem_req_addr = fetch_pc.
//  Request handshake (req_valid & req_ready):
//   fetch_pc += 4, modulo 2^XLEN; wrap from all-ones-minus-3 to 0 is legal.
//   in_flight++.
//  Response (resp_valid & resp_ready):
//   in_flight--.
//   If discard>0: drop data, discard--.
//   Else: push {pc,inst}. The pc comes from an internal issued-PC FIFO of MAX_OUTSTANDING entries.
//  Response latency: a response accepted at edge t appears as out_valid at t+1 when the queue was empty. No bypass.
//  Dequeue:
//   out_valid = (occupancy!=0) & !redirect_valid.
//   Pop on out_valid & out_ready.
//   Push and pop in the same cycle: occupancy unchanged. Full with a simultaneous pop is impossible by credit.
//  Redirect (redirect_valid=1 at edge):
//   Queue cleared; occupancy=0 next cycle.
//   fetch_pc=redirect_pc.
//   discard = in_flight - resp_fire_this_cycle, i.e. every remaining in-flight request becomes stale.
//   Issued-PC FIFO is not cleared; stale entries are popped as their responses are dropped.
//   Any response arriving in the redirect cycle is dropped.
//   No request issues in the redirect cycle.
//  Back-to-back redirects: the last one wins. discard is recomputed each time and never double-counts.
//  Errors: a response with in_flight==0 is a protocol error. Guard with an assertion; RTL ignores it.
//  Mid-operation reset: all state returns to reset values immediately. In-flight responses after reset are dropped because resp_ready=0 until run.
// STRUCTURE
//  fetch_pkg:
//   typedef fetch_entry_t {logic [XLEN-1:0] pc; logic [ILEN-1:0] inst;}
//   localparam PC_STEP=4
//   function cnt_w(depth) = $clog2(depth+1)
//  Sub-module fetch_fifo #(WIDTH,DEPTH):
//   sync FIFO with flush, async active-low reset, push/pop/full/empty/count.
//   Instantiated twice: instruction queue and issued-PC FIFO.
//  Top holds fetch_pc, in_flight, discard and run counters, plus the issue logic.
// TESTING
//  1 Reset, imem always ready, 1-cycle response latency, out_ready=1
//    -> addrs 0,4,8,...; first out_valid at cycle 3 after reset release; pcs in order.
//  2 out_ready=0, DEPTH=4, MAX_OUTSTANDING=2
//    -> exactly 4 requests issue, then req_valid=0; occupancy=4.
//    -> Raise out_ready: requests resume one per pop.
//  3 Two requests in flight (pc 8,12), redirect to 0x100
//    -> both responses dropped, next request addr 0x100, first out_pc=0x100, discard back to 0.
//  4 Redirect in the same cycle as a response and a pop
//    -> response dropped, queue empty next cycle, discard = in_flight-1.
//  5 RESET_PC=0xFFFF_FFF8
//    -> addrs FFFF_FFF8, FFFF_FFFC, 0000_0000; out_pc wraps identically.
//  6 Assert reset_n=0 with a full queue and 2 in flight
//    -> outputs 0 asynchronously; after release fetch restarts at RESET_PC; late responses ignored.

Source files
------------

// File: rtl/fetch_queue_unit_pkg.sv
// Shared types, constants and helpers for the instruction-fetch queue unit.
package fetch_queue_unit_pkg;
   localparam int XLEN_DEF = 32;
   localparam int ILEN_DEF = 32;
   localparam int PC_STEP  = 4;

   typedef struct packed {
      logic [XLEN_DEF-1:0] pc;
      logic [ILEN_DEF-1:0] inst;
   } fetch_entry_t;

   function automatic int cnt_w(input int depth);
      return $clog2(depth + 1);
   endfunction
endpackage

// File: rtl/fetch_queue_unit_if.sv
// Redirect, imem request/response and decode-side signals of the fetch queue unit.
interface fetch_queue_unit_if #(
   parameter int XLEN  = 32,
   parameter int ILEN  = 32,
   parameter int DEPTH = 4
);
   import fetch_queue_unit_pkg::*;
   localparam int OCC_W = cnt_w(DEPTH);

   logic             redirect_valid;
   logic [XLEN-1:0]  redirect_pc;
   logic             imem_req_valid;
   logic             imem_req_ready;
   logic [XLEN-1:0]  imem_req_addr;
   logic             imem_resp_valid;
   logic             imem_resp_ready;
   logic [ILEN-1:0]  imem_resp_data;
   logic             out_valid;
   logic             out_ready;
   logic [ILEN-1:0]  out_inst;
   logic [XLEN-1:0]  out_pc;
   logic [OCC_W-1:0] occupancy;

   modport master (
      input  redirect_valid, redirect_pc, imem_req_ready, imem_resp_valid,
             imem_resp_data, out_ready,
      output imem_req_valid, imem_req_addr, imem_resp_ready, out_valid,
             out_inst, out_pc, occupancy
   );

   modport slave (
      output redirect_valid, redirect_pc, imem_req_ready, imem_resp_valid,
             imem_resp_data, out_ready,
      input  imem_req_valid, imem_req_addr, imem_resp_ready, out_valid,
             out_inst, out_pc, occupancy
   );
endinterface

// File: rtl/fetch_queue_unit_fifo.sv
// Show-ahead synchronous FIFO with flush; head word is readable while count is nonzero.
module fetch_queue_unit_fifo
   import fetch_queue_unit_pkg::*;
#(
   parameter int WIDTH = 64,
   parameter int DEPTH = 4,
   localparam int CW = cnt_w(DEPTH),
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_flush,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_data,
   output logic             o_full,
   output logic             o_empty,
   output logic [CW-1:0]    o_count
);
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             w_push;
   logic             w_pop;

   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] ptr);
      return (ptr == AW'(DEPTH - 1)) ? '0 : ptr + AW'(1);
   endfunction

   assign o_full  = (r_count == CW'(DEPTH));
   assign o_empty = (r_count == '0);
   assign o_count = r_count;
   assign o_data  = r_mem[r_rd_ptr];
   assign w_push  = i_push & ~o_full & ~i_flush;
   assign w_pop   = i_pop & ~o_empty & ~i_flush;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
         if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
         r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
   end

   // Storage carries no reset; only the pointers and count define validity.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_data;
   end
endmodule

// File: rtl/fetch_queue_unit.sv
// Fetch front end: credit-limited imem requests, stale-response discard on redirect,
// and a {pc,inst} queue toward decode.
module fetch_queue_unit
   import fetch_queue_unit_pkg::*;
#(
   parameter int              XLEN            = 32,
   parameter int              ILEN            = 32,
   parameter int              DEPTH           = 4,
   parameter int              MAX_OUTSTANDING = 2,
   parameter logic [XLEN-1:0] RESET_PC        = '0
) (
   input logic              clk,
   input logic              reset_n,
   fetch_queue_unit_if.master fq
);
   localparam int OCC_W = cnt_w(DEPTH);
   localparam int IF_W  = cnt_w(MAX_OUTSTANDING);

   logic             r_run;
   logic [XLEN-1:0]  r_fetch_pc;
   logic [IF_W-1:0]  r_discard;

   logic [XLEN-1:0]      w_issued_pc;
   logic                 w_pc_full;
   logic                 w_pc_empty;
   logic [IF_W-1:0]      w_in_flight;
   logic [XLEN+ILEN-1:0] w_head;
   logic                 w_q_full;
   logic                 w_q_empty;
   logic [OCC_W-1:0]     w_occ;
   int                   w_committed;
   logic                 w_req_valid;
   logic                 w_req_fire;
   logic                 w_resp_fire;
   logic                 w_drop;
   logic                 w_push;
   logic                 w_out_valid;
   logic                 w_pop;

   // Queue slots already promised: buffered entries plus live (non-stale) requests.
   assign w_committed = int'(w_occ) + int'(w_in_flight) - int'(r_discard);
   assign w_req_valid = r_run & ~fq.redirect_valid & ~w_pc_full & (w_committed < DEPTH);
   assign w_req_fire  = w_req_valid & fq.imem_req_ready;
   assign w_resp_fire = fq.imem_resp_valid & r_run & ~w_pc_empty;
   assign w_drop      = fq.redirect_valid | (r_discard != '0);
   assign w_push      = w_resp_fire & ~w_drop & ~w_q_full;
   assign w_out_valid = ~w_q_empty & ~fq.redirect_valid;
   assign w_pop       = w_out_valid & fq.out_ready;

   assign fq.imem_req_valid  = w_req_valid;
   assign fq.imem_req_addr   = r_fetch_pc;
   assign fq.imem_resp_ready = r_run;
   assign fq.out_valid       = w_out_valid;
   assign fq.out_pc          = w_head[ILEN +: XLEN];
   assign fq.out_inst        = w_head[ILEN-1:0];
   assign fq.occupancy       = w_occ;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_run      <= 1'b0;
         r_fetch_pc <= RESET_PC;
         r_discard  <= '0;
      end else begin
         r_run <= 1'b1;
         if (fq.redirect_valid) begin
            r_fetch_pc <= fq.redirect_pc;
            r_discard  <= w_in_flight - IF_W'(w_resp_fire);
         end else begin
            if (w_req_fire) r_fetch_pc <= r_fetch_pc + XLEN'(PC_STEP);
            if (w_resp_fire && (r_discard != '0)) r_discard <= r_discard - IF_W'(1);
         end
      end
   end

   // The issued-PC FIFO count is the in-flight count, stale requests included.
   fetch_queue_unit_fifo #(.WIDTH(XLEN), .DEPTH(MAX_OUTSTANDING)) u_pc_fifo (
      .clk     (clk),
      .rst_n   (reset_n),
      .i_flush (1'b0),
      .i_push  (w_req_fire),
      .i_data  (r_fetch_pc),
      .i_pop   (w_resp_fire),
      .o_data  (w_issued_pc),
      .o_full  (w_pc_full),
      .o_empty (w_pc_empty),
      .o_count (w_in_flight)
   );

   fetch_queue_unit_fifo #(.WIDTH(XLEN + ILEN), .DEPTH(DEPTH)) u_inst_q (
      .clk     (clk),
      .rst_n   (reset_n),
      .i_flush (fq.redirect_valid),
      .i_push  (w_push),
      .i_data  ({w_issued_pc, fq.imem_resp_data}),
      .i_pop   (w_pop),
      .o_data  (w_head),
      .o_full  (w_q_full),
      .o_empty (w_q_empty),
      .o_count (w_occ)
   );

   a_no_orphan_resp: assert property (@(posedge clk) disable iff (!reset_n)
      (fq.imem_resp_valid && r_run) |-> !w_pc_empty);
endmodule

// File: tb/tb_fetch_queue_unit.sv
// Randomized bench for fetch_queue_unit against a queue-level reference model.
module tb_fetch_queue_unit;
   import fetch_queue_unit_pkg::*;

   localparam int          DEPTH  = 4;
   localparam int          MAXO   = 2;
   localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   fetch_queue_unit_if #(.XLEN(32), .ILEN(32), .DEPTH(DEPTH)) fq ();

   fetch_queue_unit #(
      .XLEN(32), .ILEN(32), .DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO), .RESET_PC(RST_PC)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .fq      (fq)
   );

   typedef struct {
      logic [31:0] pc;
      bit          stale;
   } ofl_t;

   int n_err = 0;
   int n_chk = 0;

   bit           m_run;
   logic [31:0]  m_pc;
   ofl_t         m_ofl[$];
   fetch_entry_t m_q[$];
   int           cyc;
   int           first_out;
   int           dut_fires;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cyc, got, exp);
      end
   endtask

   function automatic logic [31:0] mk_inst(input logic [31:0] pc);
      return {pc[15:0], ~pc[31:16]} ^ 32'h1357_9BDF;
   endfunction

   // One clock cycle: drive inputs, check outputs against the model, advance the model.
   task automatic step(input bit redir, input logic [31:0] rpc, input bit rq_rdy,
                       input bit rsp_en, input bit o_rdy);
      int           live;
      bit           e_req;
      bit           e_out;
      bit           rsp_v;
      ofl_t         o;
      fetch_entry_t e;
      @(negedge clk);
      rsp_v = rsp_en && (m_ofl.size() > 0);
      fq.redirect_valid  = redir;
      fq.redirect_pc     = rpc;
      fq.imem_req_ready  = rq_rdy;
      fq.imem_resp_valid = rsp_v;
      fq.imem_resp_data  = rsp_v ? mk_inst(m_ofl[0].pc) : 32'hDEAD_BEEF;
      fq.out_ready       = o_rdy;
      #1;
      live = 0;
      foreach (m_ofl[i]) if (!m_ofl[i].stale) live++;
      e_req = m_run && !redir && (m_ofl.size() < MAXO) && ((m_q.size() + live) < DEPTH);
      e_out = (m_q.size() != 0) && !redir;
      chk("req_valid", 64'(fq.imem_req_valid), 64'(e_req));
      if (e_req) chk("req_addr", 64'(fq.imem_req_addr), 64'(m_pc));
      chk("resp_ready", 64'(fq.imem_resp_ready), 64'(m_run));
      chk("out_valid", 64'(fq.out_valid), 64'(e_out));
      if (e_out) begin
         chk("out_pc", 64'(fq.out_pc), 64'(m_q[0].pc));
         chk("out_inst", 64'(fq.out_inst), 64'(m_q[0].inst));
      end
      chk("occupancy", 64'(fq.occupancy), 64'(m_q.size()));
      if (fq.imem_req_valid && rq_rdy) dut_fires++;
      if (fq.out_valid && first_out < 0) first_out = cyc;
      $display("cyc=%0d redir=%0b req=%0b addr=%08h resp=%0b out=%0b pc=%08h occ=%0d",
               cyc, redir, fq.imem_req_valid, fq.imem_req_addr, rsp_v, fq.out_valid,
               fq.out_pc, fq.occupancy);
      cyc++;
      if (e_out && o_rdy) void'(m_q.pop_front());
      if (m_run && rsp_v) begin
         o = m_ofl.pop_front();
         if (!o.stale && !redir) begin
            e.pc   = o.pc;
            e.inst = mk_inst(o.pc);
            m_q.push_back(e);
         end
      end
      if (redir) begin
         m_q.delete();
         foreach (m_ofl[i]) m_ofl[i].stale = 1'b1;
         m_pc = rpc;
      end else if (e_req && rq_rdy) begin
         o.pc    = m_pc;
         o.stale = 1'b0;
         m_ofl.push_back(o);
         m_pc = m_pc + 32'd4;
      end
      m_run = 1'b1;
   endtask

   // Asynchronous reset mid-cycle, hold with late responses, release at a negedge.
   task automatic reset_seq(input int n);
      @(negedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      chk("rst_req_valid", 64'(fq.imem_req_valid), 64'(0));
      chk("rst_out_valid", 64'(fq.out_valid), 64'(0));
      chk("rst_occupancy", 64'(fq.occupancy), 64'(0));
      chk("rst_resp_ready", 64'(fq.imem_resp_ready), 64'(0));
      m_run = 1'b0;
      m_pc  = RST_PC;
      m_q.delete();
      m_ofl.delete();
      repeat (n) begin
         @(negedge clk);
         fq.redirect_valid  = 1'b0;
         fq.imem_req_ready  = 1'b1;
         fq.imem_resp_valid = 1'b1;
         fq.imem_resp_data  = $urandom();
         fq.out_ready       = 1'b1;
         #1;
         chk("rst_hold_resp_ready", 64'(fq.imem_resp_ready), 64'(0));
         chk("rst_hold_addr", 64'(fq.imem_req_addr), 64'(RST_PC));
      end
      @(negedge clk);
      reset_n = 1'b1;
      fq.imem_resp_valid = 1'b0;
      #1;
      chk("rel_req_valid", 64'(fq.imem_req_valid), 64'(0));
      m_run     = 1'b1;
      cyc       = 1;
      first_out = -1;
   endtask

   initial begin
      logic [31:0] r;
      logic [31:0] rpc;
      fq.redirect_valid  = 1'b0;
      fq.redirect_pc     = '0;
      fq.imem_req_ready  = 1'b0;
      fq.imem_resp_valid = 1'b0;
      fq.imem_resp_data  = '0;
      fq.out_ready       = 1'b0;
      cyc = 0;
      dut_fires = 0;

      // Streaming with 1-cycle imem; addresses wrap from RESET_PC near all-ones.
      reset_seq(3);
      repeat (12) step(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
      chk("first_out_cycle", 64'(first_out), 64'(3));

      // Decode stalled: credits stop issue at DEPTH total.
      step(1'b1, 32'h0000_0100, 1'b1, 1'b1, 1'b0);
      dut_fires = 0;
      repeat (20) step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
      chk("stall_fires", 64'(dut_fires), 64'(4));
      chk("stall_occupancy", 64'(fq.occupancy), 64'(4));
      chk("stall_req_valid", 64'(fq.imem_req_valid), 64'(0));
      repeat (8) step(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);

      // Redirect with two requests in flight and no responses yet.
      repeat (3) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
      step(1'b1, 32'h0000_0100, 1'b1, 1'b0, 1'b1);
      repeat (8) step(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);

      // Redirect coinciding with a response and a pop.
      repeat (3) step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
      step(1'b1, 32'h0000_0200, 1'b1, 1'b1, 1'b1);
      repeat (8) step(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);

      // Random traffic with occasional redirects, some near the address wrap.
      repeat (600) begin
         r   = $urandom();
         rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | (r & 32'h0000_000C))
                                           : (r & 32'hFFFF_FFFC);
         step(($urandom_range(0, 15) == 0), rpc, ($urandom_range(0, 3) != 0),
              ($urandom_range(0, 2) != 0), ($urandom_range(0, 3) != 0));
      end

      // Fill the queue, then reset mid-operation and restart.
      repeat (10) step(1'b0, 32'h0, 1'b1, ($urandom_range(0, 1) == 1), 1'b0);
      reset_seq(4);
      repeat (10) step(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
      chk("first_out_cycle_after_reset", 64'(first_out), 64'(3));
      repeat (100) begin
         r = $urandom();
         step(($urandom_range(0, 15) == 0), r & 32'hFFFF_FFFC, ($urandom_range(0, 3) != 0),
              ($urandom_range(0, 2) != 0), ($urandom_range(0, 3) != 0));
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
